// File: rtl/alu_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mul_seq                                                  |
// | Description : Shift-and-add multiplier that borrows the shared pipeline    |
// |               ALU for ADDs; passes execute-stage traffic through when idle.|
// |               Optional macro ALU_MUL_EARLY_OUT_EN ends the run once the    |
// |               remaining multiplier bits are all zero.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_mul_seq #(
    parameter int         WIDTH    = 32,
    parameter logic [2:0] ALUF_ADD = 3'b010
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [2:0]       ex_f,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    output logic [WIDTH-1:0] ex_y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;

    // The ALU is adding acc + mcand this cycle; keep it only if the multiplier bit is set.
    logic [WIDTH-1:0]   w_acc_next;
    assign w_acc_next = r_mplier[0] ? alu_y : r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= a_in;
                        r_mplier <= b_in;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
`ifdef ALU_MUL_EARLY_OUT_EN
                    if (r_mplier == '0) begin
                        r_result <= r_acc;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else
`endif
                    begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + c_one;
                        if (r_count == c_last) begin
                            r_result <= w_acc_next;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // r_busy is high exactly in RUN, so it doubles as the ALU ownership select.
    assign alu_a  = r_busy ? r_acc   : ex_a;
    assign alu_b  = r_busy ? r_mcand : ex_b;
    assign alu_f  = r_busy ? ALUF_ADD : ex_f;
    assign ex_y   = alu_y;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes the unsigned 32-bit product (low WIDTH bits) of two operands by driving the shared pipeline ALU with repeated ADD operations (shift-and-add).
- Also arbitrates the single ALU between the execute stage and itself:
  - When idle, execute-stage operands and function code pass straight through.
  - While the multiply runs, the sequencer owns the ALU and stalls the pipeline.
- Sits beside the execute stage, between the ID/EX register and the ALU.

Parameters:
- WIDTH, 32: operand, ALU and result width.
- ALUF_ADD, 3'b010: ALU function code driven during multiply iterations.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- a_in  input  WIDTH  multiplicand.
- b_in  input  WIDTH  multiplier.
- ex_a  input  WIDTH  execute-stage ALU operand a.
- ex_b  input  WIDTH  execute-stage ALU operand b.
- ex_f  input  3  execute-stage ALU function code.
- alu_y  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_f.
- alu_a  output  WIDTH  operand a to the shared ALU.
- alu_b  output  WIDTH  operand b to the shared ALU.
- alu_f  output  3  function code to the shared ALU.
- ex_y  output  WIDTH  ALU result returned to execute stage (equals alu_y).
- busy  output  1  sequencer owns ALU; doubles as pipeline stall.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  product low WIDTH bits; held until next accepted start.

Behaviour:
- Reset: while reset_n=0, asynchronously force state=IDLE, acc=0, mcand=0, mplier=0, count=0, result=0, busy=0, done=0. Reset mid-RUN aborts with no done pulse.
- States: IDLE, RUN, DONE. Registered state.
- IDLE:
  - ALU muxed to execute stage: alu_a=ex_a, alu_b=ex_b, alu_f=ex_f.
  - start=1: latch mcand=a_in, mplier=b_in, acc=0, count=0; next state RUN.
- RUN:
  - busy=1; alu_a=acc, alu_b=mcand, alu_f=ALUF_ADD.
  - Each edge: if mplier[0], acc<=alu_y (wraps mod 2^WIDTH, carry discarded); mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - Leave RUN after the edge where count==WIDTH-1, i.e. exactly WIDTH iterations. Next state DONE; result<=final acc on that edge.
  - start ignored in RUN.
- DONE:
  - done=1 for this single cycle; busy=0; ALU muxed back to execute stage.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back, next state RUN); otherwise next state IDLE.
- Latency (WIDTH=32): start sampled at edge 0 -> RUN edges 1..32 -> done high in the cycle after edge 32. result is valid from that cycle.
- busy is a registered function of state: high only in RUN. ex_y is always alu_y. ex_y is meaningful to the pipeline only when busy=0.
- Operands latched at start; changes to a_in/b_in during RUN have no effect.
- a_in=0 or b_in=0 -> result 0, full latency without early-out.

Optional Feature:
- Macro ALU_MUL_EARLY_OUT_EN.
- Defined: at the start of each RUN cycle, if mplier==0, no update occurs and the next state is DONE with result<=acc. This cycle still drives the ALU and keeps busy=1. Done therefore appears msb_index(b_in)+3 cycles after the start edge, or 2 cycles for b_in=0.
- Undefined: fixed WIDTH-iteration latency as above.

Test Plan:
- Reset: assert reset_n=0 mid-RUN -> busy=0, done=0, result=0 immediately; after release, ex_f=3'b110, ex_a=9, ex_b=4 -> ex_y=5.
- Basic: start, a_in=7, b_in=6 -> busy high 32 cycles; done pulses once; result=42; alu_f=3'b010 throughout RUN.
- Wrap: a_in=32'hFFFF_FFFF, b_in=32'h0000_0002 -> result=32'hFFFF_FFFE.
- Back-to-back: start held through DONE with a_in=3, b_in=5 -> second RUN begins with no IDLE cycle; second result=15; first result=42 visible during DONE.
- Ignore: start toggled and a_in/b_in changed during RUN -> no restart; product of the latched operands delivered.
- Early-out (macro defined): a_in=10, b_in=1 -> done 3 cycles after start edge, result=10; b_in=0 -> done after 2 cycles, result=0.
